csla_bec_seq_adder: RTL and testbench
=====================================

CSLA_BEC_SEQ_ADDER -- requirements
Module: csla_bec_seq_adder

Interface
REQ-001 SHALL have parameter W, default 32, meaning operand width in bits; legal values are multiples of 4, minimum 8.
REQ-002 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port start  input  1  request to begin an addition; sampled on the rising edge of clk.
REQ-005 SHALL have port a  input  W  first operand, sampled only on the edge that accepts start.
REQ-006 SHALL have port b  input  W  second operand, sampled only on the edge that accepts start.
REQ-007 SHALL have port cin  input  1  carry-in, sampled only on the edge that accepts start.
REQ-008 SHALL have port busy  output  1  high while nibbles are being processed.
REQ-009 SHALL have port done  output  1  one-cycle pulse marking valid sum/cout.
REQ-010 SHALL have port sum  output  W  registered result.
REQ-011 SHALL have port cout  output  1  registered carry-out.

Function
REQ-012 SHALL implement the states IDLE, RUN and DONE with a nibble counter cnt ranging over 0..W/4-1.
REQ-013 SHALL accept start only when busy=0 (state IDLE or DONE), latching a, b, cin, clearing cnt and entering RUN.
REQ-014 SHALL ignore start while in RUN, with no effect on operands, counter or outputs.
REQ-015 SHALL, on each RUN edge, process nibble cnt (bits 4*cnt+3 : 4*cnt) as follows.
- 4-bit ripple-carry add of the nibble with carry-in 0, giving s0[3:0] and c0.
- 4-bit binary-to-excess-1 conversion of {c0,s0}, giving s1 = s0+1 (mod 16) and c1 = c0 OR (s0 == 4'hF).
- Running carry selects {s1,c1} when 1 and {s0,c0} when 0; the selected nibble is written to the internal accumulator and the selected carry becomes the running carry.
REQ-016 SHALL initialise the running carry to the latched cin when start is accepted.
REQ-017 SHALL, on the edge processing cnt = W/4-1, load sum from the accumulator (including that nibble), load cout from the final carry, and enter DONE.
REQ-018 SHALL meet these latency figures (W=32): start sampled at edge E0, nibbles committed at E1..E8, done=1 during the cycle after E8, i.e. 8 clocks after the start edge (W/4 in general).
REQ-019 SHALL drive busy=1 exactly during RUN, and done=1 exactly during DONE.
REQ-020 SHALL leave DONE after one cycle, going to IDLE, or to RUN if start=1 in that cycle (back-to-back operation).
REQ-021 SHALL hold sum and cout stable from DONE until the next completion; they SHALL NOT change during RUN.
REQ-022 SHALL produce, at completion, sum = (a+b+cin) mod 2^W and cout = bit W of a+b+cin for all operand values, including wrap-around.

Reset
REQ-023 SHALL, on rst=1 at a clock edge, enter IDLE and drive cnt, accumulator, running carry, busy, done, sum and cout to 0.
REQ-024 SHALL give rst priority over start; a reset during RUN aborts the operation, no done is generated, and sum/cout read 0.
REQ-025 SHALL accept start on the first edge after rst is deasserted.

Configuration
REQ-026 SHALL, when macro CSLA_OVF_EN is defined, add output port ovf (1 bit), registered with sum, equal to (a[W-1]==b[W-1]) AND (sum[W-1]!=a[W-1]), and reset to 0.
REQ-027 SHALL, when CSLA_OVF_EN is undefined, have no ovf port and no overflow logic; all other behaviour is identical.

Verification
REQ-028 SHALL cover: a=32'hFFFFFFFF, b=32'h00000001, cin=0 -> 8 cycles later done=1, sum=32'h00000000, cout=1.
REQ-029 SHALL cover: a=32'h0000000F, b=32'h00000000, cin=1 (carry through the BEC path) -> sum=32'h00000010, cout=0.
REQ-030 SHALL cover: start re-asserted with new operands at cycles 3 and 5 of RUN -> ignored; result matches the first operands; single done pulse.
REQ-031 SHALL cover: start held high through DONE -> a second operation is accepted in the DONE cycle; the second done pulse follows 8 cycles later with the correct sum.
REQ-032 SHALL cover: rst asserted at RUN cycle 4 -> busy=0, done never pulses, sum=0, cout=0; the next start completes normally.
REQ-033 SHALL cover, with CSLA_OVF_EN defined: a=32'h7FFFFFFF, b=32'h00000001, cin=0 -> sum=32'h80000000, ovf=1, cout=0; plus 1000 random operand sets compared against a+b+cin.

Source files
------------

// File: rtl/csla_bec_seq_adder.sv
// Nibble-serial carry-select adder (BEC +1 path); done pulses W/4 clocks after the start edge.
// start is ignored while busy; optional signed-overflow output ovf under macro CSLA_OVF_EN.
module csla_bec_seq_adder #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] sum,
  output logic         cout
`ifdef CSLA_OVF_EN
  ,
  output logic         ovf
`endif
);

  localparam int NN = W / 4;
  localparam int CW = (NN > 1) ? $clog2(NN) : 1;
  localparam logic [CW-1:0] LAST = CW'(NN - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state_q;
  logic [CW-1:0] cnt_q;
  logic [W-1:0]  a_q, b_q, acc_q, acc_d, sum_q;
  logic          carry_q, carry_d;
  logic          busy_q, done_q, cout_q;
  logic [3:0]    na, nb, s0, s1;
  logic          c0, c1;
`ifdef CSLA_OVF_EN
  logic          ovf_q;
`endif

  // Both nibble candidates are formed every cycle; the running carry only picks one.
  always_comb begin
    na      = a_q[{cnt_q, 2'b00} +: 4];
    nb      = b_q[{cnt_q, 2'b00} +: 4];
    {c0, s0} = {1'b0, na} + {1'b0, nb};
    s1      = s0 + 4'd1;
    c1      = c0 | (s0 == 4'hF);
    carry_d = carry_q ? c1 : c0;
    acc_d   = acc_q;
    acc_d[{cnt_q, 2'b00} +: 4] = carry_q ? s1 : s0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      carry_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
`ifdef CSLA_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE, DONE: begin
          done_q <= 1'b0;
          if (start) begin
            a_q     <= a;
            b_q     <= b;
            carry_q <= cin;
            cnt_q   <= '0;
            acc_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= RUN;
          end else begin
            state_q <= IDLE;
          end
        end
        RUN: begin
          acc_q   <= acc_d;
          carry_q <= carry_d;
          if (cnt_q == LAST) begin
            sum_q   <= acc_d;
            cout_q  <= carry_d;
`ifdef CSLA_OVF_EN
            ovf_q   <= (a_q[W-1] == b_q[W-1]) && (acc_d[W-1] != a_q[W-1]);
`endif
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= DONE;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign sum  = sum_q;
  assign cout = cout_q;
`ifdef CSLA_OVF_EN
  assign ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_csla_bec_seq_adder.sv
// Self-checking bench for csla_bec_seq_adder: directed corner cases plus random operands
// compared against a plain-arithmetic reference (a + b + cin).
module tb_csla_bec_seq_adder;

  localparam int W = 32;

  logic         clk, rst, start, cin;
  logic [W-1:0] a, b;
  logic         busy, done, cout;
  logic [W-1:0] sum;
`ifdef CSLA_OVF_EN
  logic         ovf;
`endif

  int n_cmp = 0;
  int n_mis = 0;

  csla_bec_seq_adder #(.W(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
`ifdef CSLA_OVF_EN
    ,
    .ovf   (ovf)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not reach the summary");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [W:0] model(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
    return {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Presents one operand set with start for a single edge, then scrambles the inputs.
  task automatic start_op(input logic [W-1:0] ta, input logic [W-1:0] tbv, input logic tc);
    a = ta; b = tbv; cin = tc; start = 1'b1;
    step();
    start = 1'b0;
    a = W'($urandom); b = W'($urandom); cin = ~tc;
  endtask

  // Waits (bounded) for done; checks busy, output stability, latency and result.
  task automatic wait_done(input logic [W-1:0] ea, input logic [W-1:0] eb, input logic ec,
                           input int lat0, input string tag);
    int           lat;
    logic [W:0]   prev, exp;
    lat  = lat0;
    prev = {cout, sum};
    exp  = model(ea, eb, ec);
    while (done !== 1'b1 && lat < 20) begin
      chk({tag, " busy"}, 64'(busy), 64'(1));
      chk({tag, " hold"}, 64'({cout, sum}), 64'(prev));
      step();
      lat++;
    end
    chk({tag, " latency"}, 64'(lat), 64'(W / 4));
    chk({tag, " done"}, 64'(done), 64'(1));
    chk({tag, " busy_at_done"}, 64'(busy), 64'(0));
    chk({tag, " sum"}, 64'(sum), 64'(exp[W-1:0]));
    chk({tag, " cout"}, 64'(cout), 64'(exp[W]));
`ifdef CSLA_OVF_EN
    chk({tag, " ovf"}, 64'(ovf), 64'((ea[W-1] == eb[W-1]) && (exp[W-1] != ea[W-1])));
`endif
  endtask

  initial begin
    logic [W-1:0] ra, rb;
    logic         rc;
    clk = 1'b0; rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;

    // Reset state
    step();
    step();
    rst = 1'b0;
    chk("rst busy", 64'(busy), 64'(0));
    chk("rst done", 64'(done), 64'(0));
    chk("rst sum", 64'(sum), 64'(0));
    chk("rst cout", 64'(cout), 64'(0));
`ifdef CSLA_OVF_EN
    chk("rst ovf", 64'(ovf), 64'(0));
`endif

    // Full-width carry ripple, started on the first edge after reset release
    start_op(32'hFFFFFFFF, 32'h00000001, 1'b0);
    wait_done(32'hFFFFFFFF, 32'h00000001, 1'b0, 0, "wrap");
    chk("wrap sum const", 64'(sum), 64'(32'h00000000));
    chk("wrap cout const", 64'(cout), 64'(1));
    step();
    chk("wrap done drop", 64'(done), 64'(0));

    // Carry-in absorbed through the +1 path of nibble 0
    start_op(32'h0000000F, 32'h00000000, 1'b1);
    wait_done(32'h0000000F, 32'h00000000, 1'b1, 0, "bec");
    chk("bec sum const", 64'(sum), 64'(32'h00000010));
    step();

    // Signed overflow corner
    start_op(32'h7FFFFFFF, 32'h00000001, 1'b0);
    wait_done(32'h7FFFFFFF, 32'h00000001, 1'b0, 0, "ovf");
    chk("ovf sum const", 64'(sum), 64'(32'h80000000));
    step();

    // start re-asserted during RUN is ignored
    start_op(32'h12345678, 32'h9ABCDEF0, 1'b1);
    step();
    step();
    start = 1'b1; a = 32'hDEADBEEF; b = 32'h01010101; cin = 1'b0;
    step();
    start = 1'b0;
    step();
    start = 1'b1; a = 32'hCAFEF00D; b = 32'h11111111; cin = 1'b1;
    step();
    start = 1'b0;
    wait_done(32'h12345678, 32'h9ABCDEF0, 1'b1, 5, "ign");
    step();
    chk("ign single pulse", 64'(done), 64'(0));
    chk("ign idle busy", 64'(busy), 64'(0));

    // start held high through DONE: back-to-back second operation
    a = 32'hA5A5A5A5; b = 32'h5A5A5A5B; cin = 1'b0; start = 1'b1;
    step();
    a = 32'h80000000; b = 32'h80000000; cin = 1'b1;
    wait_done(32'hA5A5A5A5, 32'h5A5A5A5B, 1'b0, 0, "b2b1");
    step();
    start = 1'b0;
    wait_done(32'h80000000, 32'h80000000, 1'b1, 0, "b2b2");
    step();

    // Reset at RUN cycle 4 aborts; next start completes normally
    start_op(32'h0F0F0F0F, 32'h01010101, 1'b0);
    step();
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("abort busy", 64'(busy), 64'(0));
    chk("abort done", 64'(done), 64'(0));
    chk("abort sum", 64'(sum), 64'(0));
    chk("abort cout", 64'(cout), 64'(0));
    start_op(32'h00FF00FF, 32'h00FF00FF, 1'b1);
    wait_done(32'h00FF00FF, 32'h00FF00FF, 1'b1, 0, "post_abort");
    step();

    // Random operands, idle gap or back-to-back at random
    for (int i = 0; i < 1000; i++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      rc = 1'($urandom_range(0, 1));
      if (i % 50 == 0) ra = 32'hFFFFFFFF;
      start_op(ra, rb, rc);
      wait_done(ra, rb, rc, 0, "rand");
      if ($urandom_range(0, 1) == 1) step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
